// File: rtl/spart_bus_ctrl_if.sv
// Bus bundle between the core, the SPART bus controller and the SPART itself.
// Handshake: a byte moves from core to controller on any rising clk edge where
// tx_valid and tx_ready are both high; tx_valid may not depend on tx_ready.
// rx_valid is a single-cycle strobe with no back-pressure.
interface spart_bus_ctrl_if;
  logic [1:0] br_cfg;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       cfg_done;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] db_out;
  logic       db_oe;
  logic [7:0] db_in;
  logic       tbr;
  logic       rda;

  // Controller view
  modport master (
    input  br_cfg, tx_valid, tx_data, db_in, tbr, rda,
    output tx_ready, rx_valid, rx_data, cfg_done, iocs, iorw, ioaddr, db_out, db_oe
  );

  // Environment view (core + SPART)
  modport slave (
    output br_cfg, tx_valid, tx_data, db_in, tbr, rda,
    input  tx_ready, rx_valid, rx_data, cfg_done, iocs, iorw, ioaddr, db_out, db_oe
  );
endinterface

// File: rtl/spart_bus_ctrl.sv
// SPART bus controller: loads the baud divisor after reset or a baud change,
// then arbitrates the single SPART data port between receive (priority) and
// a FIFO-buffered transmit path. Bus outputs are registered decodes of the
// current state, so the bus shows a state's cycle one clock after entering it.
module spart_bus_ctrl #(
  parameter logic [15:0] DIV0     = 16'h0515,
  parameter logic [15:0] DIV1     = 16'h028A,
  parameter logic [15:0] DIV2     = 16'h0145,
  parameter logic [15:0] DIV3     = 16'h00A2,
  parameter int          TX_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  spart_bus_ctrl_if.master    bus,
  output logic [2:0]          dbg_state
);

  localparam int            AW       = $clog2(TX_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(TX_DEPTH);

  typedef enum logic [2:0] {
    CFG_LO = 3'd0,
    CFG_HI = 3'd1,
    RUN    = 3'd2,
    OP     = 3'd3,
    GAP    = 3'd4
  } state_t;

  state_t      state, state_d;
  logic        op_wr, op_wr_d;
  logic [1:0]  br_q, br_q_d;
  logic        reconf;
  logic [15:0] div_sel;

  logic [7:0]    mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  logic       iocs_q, iorw_q, db_oe_q, cfg_done_q, rx_valid_q;
  logic [1:0] ioaddr_q;
  logic [7:0] db_out_q, rx_data_q;
  logic       iocs_d, iorw_d, db_oe_d, cfg_done_d;
  logic [1:0] ioaddr_d;
  logic [7:0] db_out_d;

  assign full          = (count == FULL_CNT);
  assign empty         = (count == '0);
  assign push          = bus.tx_valid & ~full;
  assign pop           = (state == OP) & op_wr;
  assign reconf        = (bus.br_cfg != br_q);
  assign bus.tx_ready  = ~full;
  assign bus.iocs      = iocs_q;
  assign bus.iorw      = iorw_q;
  assign bus.ioaddr    = ioaddr_q;
  assign bus.db_out    = db_out_q;
  assign bus.db_oe     = db_oe_q;
  assign bus.cfg_done  = cfg_done_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_data   = rx_data_q;
  assign dbg_state     = state;

  // Divisor for the baud setting latched when configuration started
  always_comb begin
    case (br_q)
      2'b00:   div_sel = DIV0;
      2'b01:   div_sel = DIV1;
      2'b10:   div_sel = DIV2;
      default: div_sel = DIV3;
    endcase
  end

  // Next state, op direction, baud latch and bus decode of the current state
  always_comb begin
    state_d    = state;
    op_wr_d    = op_wr;
    br_q_d     = br_q;
    iocs_d     = 1'b0;
    iorw_d     = 1'b0;
    ioaddr_d   = 2'b01;
    db_out_d   = 8'h00;
    db_oe_d    = 1'b0;
    cfg_done_d = 1'b0;
    case (state)
      CFG_LO: begin
        state_d  = CFG_HI;
        iocs_d   = 1'b1;
        ioaddr_d = 2'b10;
        db_out_d = div_sel[7:0];
        db_oe_d  = 1'b1;
      end
      CFG_HI: begin
        iocs_d   = 1'b1;
        ioaddr_d = 2'b11;
        db_out_d = div_sel[15:8];
        db_oe_d  = 1'b1;
        if (reconf) begin
          br_q_d  = bus.br_cfg;
          state_d = CFG_LO;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        cfg_done_d = 1'b1;
        if (reconf) begin
          br_q_d  = bus.br_cfg;
          state_d = CFG_LO;
        end else if (bus.rda) begin
          op_wr_d = 1'b0;
          state_d = OP;
        end else if (bus.tbr && !empty) begin
          op_wr_d = 1'b1;
          state_d = OP;
        end
      end
      OP: begin
        cfg_done_d = 1'b1;
        iocs_d     = 1'b1;
        iorw_d     = ~op_wr;
        ioaddr_d   = 2'b00;
        db_out_d   = op_wr ? mem[rd_ptr] : 8'h00;
        db_oe_d    = op_wr;
        // A baud change seen here waits until the op has been issued
        if (reconf) begin
          br_q_d  = bus.br_cfg;
          state_d = CFG_LO;
        end else begin
          state_d = GAP;
        end
      end
      GAP: begin
        cfg_done_d = 1'b1;
        if (reconf) begin
          br_q_d  = bus.br_cfg;
          state_d = CFG_LO;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = CFG_LO;
    endcase
  end

  // State, registered bus outputs, receive capture and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CFG_LO;
      op_wr      <= 1'b0;
      br_q       <= bus.br_cfg;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b0;
      ioaddr_q   <= 2'b01;
      db_out_q   <= 8'h00;
      db_oe_q    <= 1'b0;
      cfg_done_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_d;
      op_wr      <= op_wr_d;
      br_q       <= br_q_d;
      iocs_q     <= iocs_d;
      iorw_q     <= iorw_d;
      ioaddr_q   <= ioaddr_d;
      db_out_q   <= db_out_d;
      db_oe_q    <= db_oe_d;
      cfg_done_q <= cfg_done_d;
      // Read data is sampled at the end of the bus read cycle
      rx_valid_q <= iocs_q & iorw_q;
      if (iocs_q && iorw_q) rx_data_q <= bus.db_in;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents behind the pointers need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Directed bench for spart_bus_ctrl: configuration, ordered writes, FIFO
// back-pressure, read priority, deferred baud change and reset mid-op.
module tb_spart_bus_ctrl;

  localparam logic [2:0] S_CFG_LO = 3'd0;
  localparam logic [2:0] S_OP     = 3'd3;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         checks;
  int         failures;
  int         cyc_n;
  int         t_a, t_b, read_at;
  logic       seen;

  spart_bus_ctrl_if bus ();

  spart_bus_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock: 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; an offered byte that is accepted at this edge is withdrawn
  task automatic cyc();
    logic acc;
    acc = bus.tx_valid && bus.tx_ready;
    @(posedge clk);
    #1;
    cyc_n++;
    if (acc) bus.tx_valid = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    cyc();
  endtask

  // Wait (bounded) for a data-port write on the bus and check its byte
  task automatic wait_write(input string tag, input logic [7:0] exp, output int at);
    logic found;
    found = 1'b0;
    at    = -1;
    for (int i = 0; i < 12 && !found; i++) begin
      cyc();
      if (bus.iocs && !bus.iorw && bus.ioaddr == 2'b00) begin
        found = 1'b1;
        at    = cyc_n;
        chk(tag, {24'h0, bus.db_out}, {24'h0, exp});
      end
    end
    if (!found) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] want);
    logic found;
    found = (dbg_state == want);
    for (int i = 0; i < 12 && !found; i++) begin
      cyc();
      found = (dbg_state == want);
    end
    chk(tag, {31'h0, found}, 32'd1);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    cyc_n        = 0;
    rst          = 1'b1;
    bus.br_cfg   = 2'b01;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.db_in    = 8'h00;
    bus.tbr      = 1'b0;
    bus.rda      = 1'b0;

    // 1: reset values, then divisor load for 9600 baud
    cyc();
    cyc();
    chk("rst_iocs",     {31'h0, bus.iocs},     32'd0);
    chk("rst_ioaddr",   {30'h0, bus.ioaddr},   32'd1);
    chk("rst_db_oe",    {31'h0, bus.db_oe},    32'd0);
    chk("rst_cfg_done", {31'h0, bus.cfg_done}, 32'd0);
    chk("rst_tx_ready", {31'h0, bus.tx_ready}, 32'd1);
    chk("rst_rx_valid", {31'h0, bus.rx_valid}, 32'd0);
    chk("rst_state",    {29'h0, dbg_state},    {29'h0, S_CFG_LO});
    rst = 1'b0;
    cyc();
    chk("cfg_lo_addr", {30'h0, bus.ioaddr}, 32'h2);
    chk("cfg_lo_data", {24'h0, bus.db_out}, 32'h8A);
    chk("cfg_lo_cs",   {31'h0, bus.iocs},   32'd1);
    chk("cfg_lo_oe",   {31'h0, bus.db_oe},  32'd1);
    cyc();
    chk("cfg_hi_addr", {30'h0, bus.ioaddr}, 32'h3);
    chk("cfg_hi_data", {24'h0, bus.db_out}, 32'h02);
    chk("cfg_hi_done", {31'h0, bus.cfg_done}, 32'd0);
    cyc();
    chk("cfg_done",    {31'h0, bus.cfg_done}, 32'd1);
    chk("run_cs",      {31'h0, bus.iocs},     32'd0);

    // 2: two writes, in order, three cycles apart
    push_byte(8'h41);
    push_byte(8'h42);
    bus.tbr = 1'b1;
    wait_write("wr_41", 8'h41, t_a);
    chk("wr_41_oe", {31'h0, bus.db_oe}, 32'd1);
    wait_write("wr_42", 8'h42, t_b);
    chk("wr_spacing", t_b - t_a, 32'd3);
    bus.tbr = 1'b0;

    // 3: fill the FIFO with tbr low, fifth byte held until space frees
    for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i));
    chk("full_ready", {31'h0, bus.tx_ready}, 32'd0);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h14;
    cyc();
    cyc();
    chk("held_ready", {31'h0, bus.tx_ready}, 32'd0);
    chk("no_wr_tbr0", {31'h0, bus.iocs},     32'd0);
    bus.tbr = 1'b1;
    for (int i = 0; i < 5; i++) wait_write("drain", 8'h10 + 8'(i), t_a);
    bus.tbr = 1'b0;

    // 4: read takes priority over a pending write
    push_byte(8'h77);
    bus.rda   = 1'b1;
    bus.tbr   = 1'b1;
    bus.db_in = 8'h5A;
    cyc();
    bus.rda = 1'b0;
    cyc();
    read_at = cyc_n;
    chk("rd_cs",   {31'h0, bus.iocs},   32'd1);
    chk("rd_rw",   {31'h0, bus.iorw},   32'd1);
    chk("rd_addr", {30'h0, bus.ioaddr}, 32'd0);
    chk("rd_oe",   {31'h0, bus.db_oe},  32'd0);
    cyc();
    chk("rx_valid_hi", {31'h0, bus.rx_valid}, 32'd1);
    chk("rx_data",     {24'h0, bus.rx_data},  32'h5A);
    cyc();
    chk("rx_valid_lo", {31'h0, bus.rx_valid}, 32'd0);
    wait_write("wr_after_rd", 8'h77, t_a);
    chk("rd_wr_spacing", t_a - read_at, 32'd3);
    bus.tbr = 1'b0;

    // 5: baud change during a write is deferred until the write is issued
    push_byte(8'h61);
    push_byte(8'h62);
    push_byte(8'h63);
    bus.tbr = 1'b1;
    wait_state("reach_op_wr", S_OP);
    bus.br_cfg = 2'b11;
    bus.tbr    = 1'b0;
    cyc();
    chk("defer_wr_cs",   {31'h0, bus.iocs},   32'd1);
    chk("defer_wr_addr", {30'h0, bus.ioaddr}, 32'd0);
    chk("defer_wr_data", {24'h0, bus.db_out}, 32'h61);
    cyc();
    chk("recfg_lo_addr", {30'h0, bus.ioaddr},   32'h2);
    chk("recfg_lo_data", {24'h0, bus.db_out},   32'hA2);
    chk("recfg_done",    {31'h0, bus.cfg_done}, 32'd0);
    cyc();
    chk("recfg_hi_addr", {30'h0, bus.ioaddr}, 32'h3);
    chk("recfg_hi_data", {24'h0, bus.db_out}, 32'h00);
    cyc();
    chk("recfg_run", {31'h0, bus.cfg_done}, 32'd1);
    push_byte(8'h64);
    chk("keep_ready3", {31'h0, bus.tx_ready}, 32'd1);
    push_byte(8'h65);
    chk("keep_full4", {31'h0, bus.tx_ready}, 32'd0);
    bus.tbr = 1'b1;
    wait_write("keep_62", 8'h62, t_a);
    wait_write("keep_63", 8'h63, t_a);
    wait_write("keep_64", 8'h64, t_a);
    wait_write("keep_65", 8'h65, t_a);
    bus.tbr = 1'b0;

    // 6: reset during a write aborts it and flushes the FIFO
    for (int i = 0; i < 4; i++) push_byte(8'h81 + 8'(i));
    chk("pre_rst_full", {31'h0, bus.tx_ready}, 32'd0);
    bus.tbr = 1'b1;
    wait_state("reach_op_rst", S_OP);
    rst = 1'b1;
    cyc();
    chk("abort_cs",    {31'h0, bus.iocs},     32'd0);
    chk("abort_ready", {31'h0, bus.tx_ready}, 32'd1);
    chk("abort_done",  {31'h0, bus.cfg_done}, 32'd0);
    chk("abort_state", {29'h0, dbg_state},    {29'h0, S_CFG_LO});
    rst = 1'b0;
    cyc();
    chk("rerun_lo_data", {24'h0, bus.db_out}, 32'hA2);
    chk("rerun_lo_addr", {30'h0, bus.ioaddr}, 32'h2);
    cyc();
    chk("rerun_hi_data", {24'h0, bus.db_out}, 32'h00);
    cyc();
    chk("rerun_done", {31'h0, bus.cfg_done}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (bus.iocs || bus.rx_valid) seen = 1'b1;
    end
    chk("flushed_no_op", {31'h0, seen}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
